// File: rtl/video_fb.sv
// video_fb: framebuffer scan-out. Programmable raster timing plus a burst fetch engine feeding a line FIFO.
// Latency: sync/de/rgb are registered, 1 clk after the ce cycle that produced them; fetch runs every clk.
// Backpressure: a burst is requested only when the FIFO has room for it; an empty FIFO at a pixel pop sets underflow.

// video_fb_fifo: generic synchronous FIFO with combinational head-of-queue read and synchronous flush.
// Latency: a pushed word is visible at out_dat on the next clk; pop takes effect on the clk edge.
// Backpressure: pushes while full are dropped (callers reserve space); pops while empty are ignored.
module video_fb_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_vld,
  input  logic [W-1:0]  in_dat,
  input  logic          out_rdy,
  output logic          out_vld,
  output logic [W-1:0]  out_dat,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign out_vld = (count != '0);
  assign out_dat = mem[rd_ptr];
  assign push    = in_vld && (count != FULL_CNT);
  assign pop     = out_rdy && out_vld;

  // Storage array; no reset needed, validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_dat;
  end

  // Pointer and occupancy tracking; flush wins over any push/pop in the same clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// video_fb: raster timing generator, burst fetch FSM and pixel unpacker around a line FIFO.
// Latency: hsync/vsync/de/rgb reflect the counters of the previous ce cycle (1 clk); frame_start is 1 clk after the restart ce cycle.
// Backpressure: rd_req is held with a stable rd_addr until rd_ack; bursts start only when BURST words of FIFO space are free.
module video_fb #(
  parameter int CORDW      = 11,
  parameter int H_RES      = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_RES      = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int ADDR_W     = 24,
  parameter int FIFO_DEPTH = 64,
  parameter int BURST      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mode,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [31:0]       rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [15:0]       rgb,
  output logic              frame_start,
  output logic              underflow
);

  localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int BEAT_W  = $clog2(BURST + 1);

  localparam logic [CORDW-1:0]  H_LAST    = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0]  V_LAST    = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0]  H_ACT     = CORDW'(H_RES);
  localparam logic [CORDW-1:0]  V_ACT     = CORDW'(V_RES);
  localparam logic [CORDW-1:0]  HS_BEG    = CORDW'(H_RES + H_FP);
  localparam logic [CORDW-1:0]  HS_END    = CORDW'(H_RES + H_FP + H_SYNC);
  localparam logic [CORDW-1:0]  VS_BEG    = CORDW'(V_RES + V_FP);
  localparam logic [CORDW-1:0]  VS_END    = CORDW'(V_RES + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] WORDS_565 = ADDR_W'(H_RES * V_RES / 2);
  localparam logic [ADDR_W-1:0] WORDS_332 = ADDR_W'(H_RES * V_RES / 4);
  localparam logic [ADDR_W-1:0] BURST_A   = ADDR_W'(BURST);
  localparam logic [CNT_W-1:0]  FILL_MAX  = CNT_W'(FIFO_DEPTH - BURST);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  // Raster position
  logic [CORDW-1:0] hcnt;
  logic [CORDW-1:0] vcnt;
  logic             hs_on;
  logic             vs_on;
  logic             de_c;
  logic             restart_evt;

  // Fetch engine
  state_t            state;
  logic              restart_pend;
  logic [ADDR_W-1:0] base_q;
  logic              mode_q;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] frame_words;
  logic [BEAT_W-1:0] beat_cnt;
  logic              flush;

  // Line FIFO
  logic              push_vld;
  logic              fifo_out_vld;
  logic [31:0]       fifo_out_dat;
  logic              pop_rdy;
  logic [CNT_W-1:0]  fifo_count;

  // Pixel unpacker
  logic [31:0]       sh_dat;
  logic [1:0]        sh_cnt;
  logic              need_word;
  logic [31:0]       src_dat;
  logic [31:0]       sh_nxt;
  logic [1:0]        cnt_nxt;
  logic [15:0]       pix_dat;

  function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
    return {p[7:5], p[7:6], p[4:2], p[4:2], p[1:0], p[1:0], p[1]};
  endfunction

  assign hs_on       = (hcnt >= HS_BEG) && (hcnt < HS_END);
  assign vs_on       = (vcnt >= VS_BEG) && (vcnt < VS_END);
  assign de_c        = (hcnt < H_ACT) && (vcnt < V_ACT);
  assign restart_evt = ce && (hcnt == '0) && (vcnt == V_ACT);

  assign frame_words = mode_q ? WORDS_332 : WORDS_565;
  assign flush       = (state == IDLE) && restart_pend;
  // Beats belonging to a burst interrupted by a restart are consumed but not stored.
  assign push_vld    = (state == DATA) && rd_valid && !restart_pend;

  // A new word is needed at the first pixel of each packed word.
  assign need_word = ce && de_c && (sh_cnt == 2'd0);
  assign pop_rdy   = need_word;
  assign src_dat   = (sh_cnt != 2'd0) ? sh_dat : (fifo_out_vld ? fifo_out_dat : 32'h0);
  assign pix_dat   = mode_q ? rgb332_to_565(src_dat[7:0]) : src_dat[15:0];
  assign sh_nxt    = mode_q ? {8'h00, src_dat[31:8]} : {16'h0000, src_dat[31:16]};
  assign cnt_nxt   = (sh_cnt != 2'd0) ? (sh_cnt - 2'd1) : (mode_q ? 2'd3 : 2'd1);

  video_fb_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_line_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_vld  (push_vld),
    .in_dat  (rd_data),
    .out_rdy (pop_rdy),
    .out_vld (fifo_out_vld),
    .out_dat (fifo_out_dat),
    .count   (fifo_count)
  );

  // Horizontal/vertical counters; advance only on pixel-enable cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      vcnt <= V_ACT;
    end else if (ce) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Registered sync/enable outputs and the frame restart pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= restart_evt;
      if (ce) begin
        hsync <= hs_on ? HS_POL : ~HS_POL;
        vsync <= vs_on ? VS_POL : ~VS_POL;
        de    <= de_c;
      end
    end
  end

  // Fetch FSM: applies pending restarts in IDLE, issues bursts, counts beats; never abandons an accepted burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      offset       <= '0;
      beat_cnt     <= '0;
      base_q       <= '0;
      mode_q       <= 1'b0;
      restart_pend <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (restart_pend) begin
            restart_pend <= 1'b0;
            base_q       <= base_addr;
            mode_q       <= mode;
            offset       <= '0;
          end else if ((offset < frame_words) && (fifo_count <= FILL_MAX)) begin
            state   <= REQ;
            rd_req  <= 1'b1;
            rd_addr <= base_q + offset;
          end
        end
        REQ: begin
          if (rd_ack) begin
            state    <= DATA;
            rd_req   <= 1'b0;
            beat_cnt <= '0;
          end
        end
        DATA: begin
          if (rd_valid) begin
            if (beat_cnt == LAST_BEAT) begin
              state  <= IDLE;
              offset <= offset + BURST_A;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A restart arriving in the same clk as a restart being applied stays pending.
      if (restart_evt) restart_pend <= 1'b1;
    end
  end

  // Pixel unpacker: LSB-first pixels from the FIFO head; empty FIFO yields black and flags underflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_dat    <= '0;
      sh_cnt    <= 2'd0;
      rgb       <= 16'h0000;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        sh_cnt <= 2'd0;
      end else if (ce && de_c) begin
        sh_dat <= sh_nxt;
        sh_cnt <= cnt_nxt;
      end
      if (need_word && !fifo_out_vld) underflow <= 1'b1;
      if (ce) rgb <= de_c ? pix_dat : 16'h0000;
    end
  end

endmodule

// File: tb/tb_video_fb.sv
// Bench for video_fb: small raster, zero-wait memory model with stall control, scoreboard on rgb.
// Expected pixels are pushed per frame at frame_start; a monitor pops one per active ce output.
module tb_video_fb;

  localparam int ADDR_W = 24;
  localparam int BURST  = 4;

  logic              clk;
  logic              reset;
  logic              ce;
  logic [ADDR_W-1:0] base_addr;
  logic              mode;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              hsync;
  logic              vsync;
  logic              de;
  logic [15:0]       rgb;
  logic              frame_start;
  logic              underflow;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0]       exp_q [$];
  logic [ADDR_W-1:0] req_log [$];
  logic [15:0]       last_exp = 16'h0;
  logic              stall  = 1'b0;
  logic              mon_en = 1'b1;
  int                beats_left = 0;
  logic [ADDR_W-1:0] cur_addr;

  // Hand-computed RGB332 -> RGB565 results for the four mode-1 pattern words, LSB pixel first.
  logic [15:0] e332 [16] = '{
    16'h0000, 16'hF81F, 16'hFFFF, 16'h0000,   // 32'h00FFE300
    16'hFFFF, 16'hFFFF, 16'hF81F, 16'hF81F,   // 32'hE3E3FFFF
    16'h07E0, 16'h9495, 16'h4A4A, 16'h212A,   // 32'h2549921C
    16'hF81F, 16'h0000, 16'h0000, 16'h0000    // 32'h000000E3
  };

  video_fb #(
    .CORDW(11), .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .ADDR_W(ADDR_W), .FIFO_DEPTH(8), .BURST(BURST)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .base_addr(base_addr), .mode(mode),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb),
    .frame_start(frame_start), .underflow(underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] j;
    if (a >= ADDR_W'(1000)) begin
      j = a - ADDR_W'(1000);
      case (j[1:0])
        2'd0:    return 32'h00FFE300;
        2'd1:    return 32'hE3E3FFFF;
        2'd2:    return 32'h2549921C;
        default: return 32'h000000E3;
      endcase
    end
    return {16'(2 * a + 1), 16'(2 * a)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  task automatic wait_fs();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 400);
    if (frame_start !== 1'b1) timeout("frame_start_wait");
  endtask

  task automatic push_mode0(input int b);
    for (int p = 0; p < 32; p++) exp_q.push_back(16'(2 * b + p));
  endtask

  task automatic push_mode1();
    for (int w = 0; w < 8; w++)
      for (int k = 0; k < 4; k++) exp_q.push_back(e332[(w % 4) * 4 + k]);
  endtask

  task automatic push_black();
    for (int p = 0; p < 32; p++) exp_q.push_back(16'h0000);
  endtask

  // Arbiter/memory model: ack one request at a time, then BURST consecutive beats; stall freezes it.
  initial begin
    rd_ack   = 1'b0;
    rd_valid = 1'b0;
    rd_data  = 32'h0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      rd_ack   = 1'b0;
      rd_valid = 1'b0;
      if (reset) begin
        beats_left = 0;
      end else if (!stall) begin
        if (beats_left > 0) begin
          rd_valid = 1'b1;
          rd_data  = mem_word(cur_addr);
          cur_addr = cur_addr + 1'b1;
          beats_left--;
        end else if (rd_req) begin
          rd_ack     = 1'b1;
          cur_addr   = rd_addr;
          beats_left = BURST;
          req_log.push_back(rd_addr);
        end
      end
    end
  end

  // Scoreboard monitor: each ce-advanced output with de high consumes one expected pixel.
  initial begin
    logic       cev;
    logic       rst_s;
    logic [15:0] e;
    forever begin
      @(posedge clk);
      cev   = ce;
      rst_s = reset;
      #1;
      if (!rst_s && cev) begin
        if (!de) begin
          chk("rgb_blank", 32'(rgb), 32'h0);
        end else if (mon_en) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL pix_extra: actual=%h required=none at %0t", rgb, $time);
          end else begin
            e = exp_q.pop_front();
            last_exp = e;
            chk("pix", 32'(rgb), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b0;
    ce        = 1'b1;
    base_addr = '0;
    mode      = 1'b0;
    #1 reset  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rd_req", 32'(rd_req), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    chk("rst_hsync", 32'(hsync), 32'h1);
    chk("rst_vsync", 32'(vsync), 32'h1);
    chk("rst_de", 32'(de), 32'h0);
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_frame_start", 32'(frame_start), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    reset = 1'b0;

    // Frame 0: raster timing over one 98-clk period, mode 0 from address 0.
    wait_fs();
    push_mode0(0);
    for (int i = 0; i < 98; i++) begin
      int h;
      int v;
      if (i > 0) @(negedge clk);
      h = i % 14;
      v = (4 + i / 14) % 7;
      chk("hsync", 32'(hsync), 32'(!(h >= 10 && h <= 12)));
      chk("vsync", 32'(vsync), 32'(!(v == 5)));
      chk("de", 32'(de), 32'(h < 8 && v < 4));
      chk("frame_start_pulse", 32'(frame_start), 32'(i == 0));
    end
    @(negedge clk);
    chk("frame_period", 32'(frame_start), 32'h1);
    if (frame_start !== 1'b1) wait_fs();

    // Frame 1: ack withheld 20 clk on the first request, then a pixel-enable pause.
    push_mode0(0);
    stall = 1'b1;
    req_log.delete();
    n = 0;
    while (rd_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_raise", 32'(rd_req), 32'h1);
    chk("req_addr_first", 32'(rd_addr), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("req_hold", 32'(rd_req), 32'h1);
      chk("addr_hold", 32'(rd_addr), 32'h0);
    end
    stall = 1'b0;
    n = 0;
    while (req_log.size() < 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (req_log.size() < 2) timeout("next_request");
    else begin
      chk("ack_addr_first", 32'(req_log[0]), 32'h0);
      chk("ack_addr_next", 32'(req_log[1]), 32'(BURST));
    end
    n = 0;
    while (de !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (de !== 1'b1) timeout("de_wait");
    ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ce_hold_de", 32'(de), 32'h1);
      chk("ce_hold_hsync", 32'(hsync), 32'h1);
      chk("ce_hold_vsync", 32'(vsync), 32'h1);
      chk("ce_hold_rgb", 32'(rgb), 32'(last_exp));
    end
    ce = 1'b1;
    mode      = 1'b1;
    base_addr = ADDR_W'(1000);

    // Frame 2: RGB332 expansion, 4 pixels per word.
    wait_fs();
    push_mode1();
    repeat (4) @(negedge clk);
    mode      = 1'b0;
    base_addr = ADDR_W'(20);

    // Frame 3: mode 0 from a new base address.
    wait_fs();
    push_mode0(20);

    // Frame 4: arbiter stalled all frame -> black active area and underflow.
    wait_fs();
    chk("underflow_clear", 32'(underflow), 32'h0);
    stall = 1'b1;
    push_black();
    repeat (4) @(negedge clk);
    base_addr = ADDR_W'(50);

    // Frame 5: released after restart; stale burst completes, then the new base is fetched.
    wait_fs();
    chk("underflow_set", 32'(underflow), 32'h1);
    req_log.delete();
    push_mode0(50);
    stall = 1'b0;
    n = 0;
    while (req_log.size() < 2 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (req_log.size() < 2) timeout("recover_request");
    else begin
      chk("stale_burst_addr", 32'(req_log[0]), 32'd20);
      chk("recover_addr", 32'(req_log[1]), 32'd50);
    end

    // Frame 6: freeze a burst after two beats and let the next restart land mid-DATA.
    wait_fs();
    chk("underflow_sticky", 32'(underflow), 32'h1);
    mon_en = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (beats_left != 2 && n < 100);
    if (beats_left != 2) timeout("mid_burst_wait");
    stall = 1'b1;
    req_log.delete();
    base_addr = ADDR_W'(200);

    // Frame 7: remaining beats drop, first request uses the new base.
    wait_fs();
    mon_en = 1'b1;
    push_mode0(200);
    stall = 1'b0;
    n = 0;
    while (req_log.size() < 1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (req_log.size() < 1) timeout("restart_request");
    else chk("restart_addr", 32'(req_log[0]), 32'd200);

    wait_fs();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_fb.md
# video_fb

Parametrised framebuffer scan-out controller: generates programmable VGA-style timing and fetches pixel words from memory in bursts through a line FIFO. It replaces the fixed 16-bit, word-at-a-time scanner. New capabilities: selectable 16 bpp / 8 bpp formats, configurable sync polarity, burst reads with a request/acknowledge handshake, blanking-time prefetch and an underflow flag. It sits between the SDRAM arbiter read port and the display encoder, in a single clock domain; pixel rate is set by `ce`.

## Interface
- CORDW, 11, counter width (bits)
- H_RES / H_FP / H_SYNC / H_BP, 640/16/96/48, horizontal active, front porch, sync, back porch (pixels)
- V_RES / V_FP / V_SYNC / V_BP, 480/10/2/33, vertical equivalents (lines)
- HS_POL / VS_POL, 0/0, active sync level (1 = active-high)
- ADDR_W, 24, word-address width
- FIFO_DEPTH, 64, line FIFO depth in 32-bit words (power of 2)
- BURST, 8, words per read burst; must be ≤ FIFO_DEPTH and divide the frame word count
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- ce  in  1  pixel enable: timing and pixel pipeline advance only when high
- base_addr  in  ADDR_W  framebuffer word address, sampled at frame restart
- mode  in  1  0 = RGB565, 2 px/word; 1 = RGB332, 4 px/word; sampled at frame restart
- rd_req  out  1  burst request
- rd_addr  out  ADDR_W  burst start word address
- rd_ack  in  1  arbiter accepts the request
- rd_valid  in  1  one data beat
- rd_data  in  32  beat data
- hsync, vsync  out  1  syncs at the programmed polarity
- de  out  1  active video
- rgb  out  16  RGB565 pixel; 0 when de = 0
- frame_start  out  1  one-clk pulse at frame restart
- underflow  out  1  sticky; set when a pixel is needed and the FIFO is empty

## Operation
- **Reset values:** hcnt = 0, vcnt = V_RES (start of vertical blank), restart pending = 1. Outputs: rd_req = 0, rd_addr = 0, hsync = ~HS_POL, vsync = ~VS_POL, de = 0, rgb = 0, frame_start = 0, underflow = 0. FIFO empty; FSM in IDLE.
- **Counters:** on a ce cycle, hcnt wraps at H_TOTAL-1 to 0. vcnt increments on the hcnt wrap and wraps at V_TOTAL-1.
- **Sync and enable:** hsync is active for H_RES+H_FP ≤ hcnt < H_RES+H_FP+H_SYNC; vsync likewise with the vertical parameters. de = (hcnt < H_RES) & (vcnt < V_RES).
- **Restart event:** the ce cycle with hcnt = 0 and vcnt = V_RES. It sets restart-pending and pulses frame_start.
  - Restart is applied when the FSM is in IDLE: flush the FIFO, latch base_addr and mode, word offset = 0.
  - Words per frame = H_RES·V_RES/2 (mode 0) or H_RES·V_RES/4 (mode 1).
- **Fetch FSM states:**
  - IDLE → REQ when not restart-pending, words remaining > 0 and fifo_count + BURST ≤ FIFO_DEPTH.
  - REQ: hold rd_req = 1 and rd_addr = base + offset until rd_ack. rd_addr is stable while rd_req is high. On rd_ack, go to DATA.
  - DATA: count BURST rd_valid beats, pushing each into the FIFO. After the last beat, offset += BURST and return to IDLE.
  - If restart becomes pending during REQ or DATA, the burst completes (the handshake is never abandoned). Remaining beats are discarded, not pushed.
  - rd_valid outside DATA is ignored.
- **Pixel pipeline:** word pixel order is LSB first. A new word is popped when de is active and the shifter is empty; the shifter holds 2 or 4 pixels.
  - If the FIFO is empty at a pop: output rgb = 0 for that word's pixels and set underflow. Alignment is recovered at the next restart.
- **RGB332 → 565 expansion:** R = {r[2:0], r[2:1]}; G = {g[2:0], g[2:0]}; B = {b[1:0], b[1:0], b[1]}.
- **Simultaneous push and pop:** fifo_count is unchanged.

## Timing
- hsync, vsync, de and rgb are registered. They reflect the counter state of the preceding ce cycle, and all four are mutually aligned, so there is 1 clk latency after ce. They hold when ce = 0.
- Fetch runs every clk, independent of ce. Prefetch during vertical blank fills the FIFO before line 0.
- frame_start is high exactly 1 clk.
- Asynchronous reset mid-burst drops rd_req immediately. The arbiter is required to abort on reset.

## Test plan
- **Timing:** H_RES=8, H_FP=2, H_SYNC=3, H_BP=1, V_RES=4, V_FP=1, V_SYNC=1, V_BP=1, ce always 1 -> hsync active for hcnt 10..12; 14 clk per line; vsync active on line 5; de on 32 cycles per frame; period = 14·7 clk.
- **Mode 0 scan-out:** memory word k = {16'(2k+1), 16'(2k)}, BURST = 4, FIFO_DEPTH = 8, zero-wait arbiter -> rgb sequence 0,1,2,…,31 over the active area; underflow stays 0.
- **Mode 1:** byte value 0xE3 -> rgb = 0xF81F; byte values 0x00 → 0x0000 and 0xFF → 0xFFFF; 4 pixels per popped word.
- **Handshake:** rd_ack withheld 20 clk -> rd_req and rd_addr stay stable; after ack, the next rd_addr = previous + BURST.
- **Underflow:** arbiter stalled all frame -> rgb = 0 in the active area, underflow = 1 and sticky. Arbiter released -> the next frame starts correctly at base_addr.
- **Restart during burst:** vsync restart arrives mid-DATA -> remaining beats are dropped, FIFO is flushed, and the first request of the new frame carries the new base_addr.
